// File: rtl/lsu_ctrl.sv
// Load/store controller between the MEM stage and a word-addressed synchronous-read data memory.
// Handles byte/half/word RV32I accesses with read-modify-write for sub-word stores.
module lsu_ctrl #(
  parameter int NumEntries = 31,
  parameter int IdxWidth   = $clog2(NumEntries)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [2:0]          req_funct3_i,
  input  logic [31:0]         req_addr_i,
  input  logic [31:0]         req_wdata_i,
  output logic                rsp_valid_o,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                mem_wr_valid_o,
  output logic [IdxWidth-1:0] mem_wr_addr_o,
  output logic [31:0]         mem_wr_data_o,
  output logic                mem_rd_valid_o,
  output logic [IdxWidth-1:0] mem_rd_addr_o,
  input  logic [31:0]         mem_rd_data_i
);

  typedef enum logic [2:0] {IDLE, LOAD_RD, STORE_RD, STORE_WR, RESP} state_t;

  state_t              r_state, w_next;
  logic [IdxWidth-1:0] r_idx;
  logic [1:0]          r_lane;
  logic [2:0]          r_funct3;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic        w_accept, w_f3_ok, w_align_ok, w_range_ok, w_illegal;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_ext, w_merged;

  assign w_accept = req_valid_i && (r_state == IDLE);

  always_comb begin
    w_f3_ok = 1'b0;
    if (req_we_i) w_f3_ok = req_funct3_i inside {3'b000, 3'b001, 3'b010};
    else          w_f3_ok = req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    w_align_ok = 1'b1;
    case (req_funct3_i[1:0])
      2'b01:   w_align_ok = ~req_addr_i[0];
      2'b10:   w_align_ok = (req_addr_i[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
    // Range is judged on the full word address so out-of-range words can never alias.
    w_range_ok = (req_addr_i[31:2] < 30'(NumEntries));
    w_illegal  = ~(w_f3_ok & w_align_ok & w_range_ok);
  end

  always_comb begin
    w_ld_byte = mem_rd_data_i[7:0];
    case (r_lane)
      2'd0: w_ld_byte = mem_rd_data_i[7:0];
      2'd1: w_ld_byte = mem_rd_data_i[15:8];
      2'd2: w_ld_byte = mem_rd_data_i[23:16];
      2'd3: w_ld_byte = mem_rd_data_i[31:24];
      default: w_ld_byte = mem_rd_data_i[7:0];
    endcase
    w_ld_half = r_lane[1] ? mem_rd_data_i[31:16] : mem_rd_data_i[15:0];
    case (r_funct3)
      3'b000:  w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_ext = {24'd0, w_ld_byte};
      3'b001:  w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_ext = {16'd0, w_ld_half};
      default: w_ld_ext = mem_rd_data_i;
    endcase
  end

  always_comb begin
    w_merged = mem_rd_data_i;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_lane)
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = mem_rd_data_i;
      endcase
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_illegal)                        w_next = RESP;
          else if (!req_we_i)                   w_next = LOAD_RD;
          else if (req_funct3_i[1:0] == 2'b10)  w_next = STORE_WR;
          else                                  w_next = STORE_RD;
        end
      end
      LOAD_RD:  w_next = RESP;
      STORE_RD: w_next = STORE_WR;
      STORE_WR: w_next = RESP;
      RESP:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_lane   <= '0;
      r_funct3 <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx    <= req_addr_i[IdxWidth+1:2];
            r_lane   <= req_addr_i[1:0];
            r_funct3 <= req_funct3_i;
            r_wdata  <= req_wdata_i;
            r_rdata  <= '0;
            r_err    <= w_illegal;
          end
        end
        LOAD_RD:  r_rdata <= w_ld_ext;
        STORE_RD: r_wdata <= w_merged;
        default: ;
      endcase
    end
  end

  assign req_ready_o    = (r_state == IDLE);
  assign rsp_valid_o    = (r_state == RESP);
  assign rsp_rdata_o    = r_rdata;
  assign rsp_err_o      = r_err;
  assign mem_rd_valid_o = (r_state == LOAD_RD) || (r_state == STORE_RD);
  assign mem_wr_valid_o = (r_state == STORE_WR);
  assign mem_rd_addr_o  = r_idx;
  assign mem_wr_addr_o  = r_idx;
  assign mem_wr_data_o  = r_wdata;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the pipeline's MEM stage and the word-addressed data memory (`mem_Rsync`, `NumEntries` words of 32 bits). It accepts one byte-addressed RV32I load/store at a time (LB/LH/LW/LBU/LHU/SB/SH/SW). It drives the memory's word read/write ports, performs read-modify-write for sub-word stores, and sign- or zero-extends load data. Misaligned or out-of-range requests are rejected with an error response and never touch memory.

## Interface
Parameters:
- `NumEntries`, 31: number of 32-bit words in the attached memory; must match the memory instance.
- `IdxWidth`, `$clog2(NumEntries)`: derived memory word-index width; not overridden.

Ports:
- `clk_i` in 1: single clock; all state updates on posedge.
- `reset_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: high only in IDLE; a request is accepted when `req_valid_i & req_ready_o` at a posedge.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: RV32I funct3 (size/sign).
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, right-aligned.
- `rsp_valid_o` out 1: one-cycle response strobe; no backpressure.
- `rsp_rdata_o` out 32: extended load data; 0 for stores and errors.
- `rsp_err_o` out 1: misaligned, out-of-range or illegal funct3.
- `mem_wr_valid_o` out 1: memory write enable.
- `mem_wr_addr_o` out IdxWidth: memory write word index.
- `mem_wr_data_o` out 32: memory write data.
- `mem_rd_valid_o` out 1: memory read enable.
- `mem_rd_addr_o` out IdxWidth: memory read word index.
- `mem_rd_data_i` in 32: memory read data.

## Operation
- On accept, register `addr`, `funct3`, `we` and `wdata`.
- Word index is `addr[IdxWidth+1:2]`. Byte lane is `addr[1:0]`.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 is an error.
- Alignment: halfword accesses require `addr[0]==0`. Word accesses require `addr[1:0]==0`.
- Range: `addr[31:2] >= NumEntries` is an error.
- FSM states: IDLE, LOAD_RD, STORE_RD, STORE_WR, RESP.
  - IDLE: ready=1. On accept, the next state is RESP with err=1 if the request is illegal. Otherwise a load goes to LOAD_RD, SW goes to STORE_WR with the merge word = wdata, and SB/SH go to STORE_RD.
  - LOAD_RD: `mem_rd_valid_o`=1, `mem_rd_addr_o`=index. At posedge, extract the byte or half at the lane, extend it (sign for LB/LH, zero for LBU/LHU), register it into `rsp_rdata_o`, then go to RESP.
  - STORE_RD: read as in LOAD_RD. At posedge, merge the low byte/half of wdata into the lane of `mem_rd_data_i`, then go to STORE_WR.
  - STORE_WR: `mem_wr_valid_o`=1 for exactly this cycle, with the index and merged word. Then go to RESP.
  - RESP: `rsp_valid_o`=1 for exactly one cycle, then go to IDLE. `rsp_err_o` and `rsp_rdata_o` hold the registered result.
- Memory strobes are decoded from state only. They are 0 in IDLE and RESP, and 0 for every error request.
- `mem_wr_addr_o`, `mem_rd_addr_o` and `mem_wr_data_o` come from the registered request. They are don't-care outside their strobe states.
- `req_*` inputs are ignored while not in IDLE.

## Timing
- Reset (async, immediate): state=IDLE, `req_ready_o`=1. All other outputs are 0: `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`, both strobes, both addresses and write data.
- Accept cycle = C. `rsp_valid_o` is high in:
  - error: C+1;
  - load: C+2;
  - SW: C+2, with the write in C+1;
  - SB/SH: C+3, with the read in C+1 and the write in C+2.
- Next accept is possible in the cycle after RESP. Minimum load throughput is 1 per 3 cycles.
- Memory read: the memory samples `mem_rd_valid_o` on negedge mid-cycle. `mem_rd_data_i` is stable by the closing posedge, where lsu_ctrl samples it.
- Memory write commits at the posedge closing STORE_WR. A load issued immediately after returns the new data.
- Reset mid-operation: the FSM returns to IDLE and the strobes drop at once. No write is issued for the abandoned request, and no response is produced.
- Out-of-range words never alias: index wrap is impossible because the range check precedes any access.

## Test plan
- Reset held then released with `req_valid_i`=0 -> all outputs 0, `req_ready_o`=1, and no strobes for 10 cycles.
- SW 0xDEADBEEF @0x08, then LW @0x08 -> write idx 2 in C+1, rsp C+2 err=0 rdata=0; load reads idx 2, rsp rdata=0xDEADBEEF at C+2.
- SB 0x000000AA @0x09 over 0xDEADBEEF -> read idx 2 in C+1, write 0xDEADAAEF in C+2, rsp C+3. Then LB @0x09 -> 0xFFFFFFAA; LBU @0x09 -> 0x000000AA.
- SH 0x00001234 @0x0A -> word 0x1234AAEF. LH @0x0A -> 0x00001234; LH @0x08 -> 0xFFFFAAEF; LHU @0x08 -> 0x0000AAEF.
- Error cases each give rsp_err=1, rdata=0 at C+1, with both strobes 0 throughout:
  - LW @0x06;
  - LH @0x03;
  - SW @0x7C (idx 31 ≥ 31);
  - load funct3=011.
- Reset pulse during the STORE_RD cycle of SB @0x08 -> `mem_wr_valid_o` never rises, no `rsp_valid_o`, `req_ready_o`=1 after release. A following LW @0x08 returns the unmodified word.
